// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage sequencer: request opcodes, FSM states
// and the default bus widths.
package mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_PUSH16 = 3'd3,
        OP_POP16  = 3'd4,
        OP_PUSH32 = 3'd5,
        OP_POP32  = 3'd6
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2
    } state_e;

    function automatic logic is_wide(input mem_op_e op);
        return (op == OP_PUSH32) || (op == OP_POP32);
    endfunction

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register (grows down, points at next free word) with
// neighbour addresses and push/pop bound checks for the sequencer.
module stack_pointer #(
    parameter int ADDR_W   = 32,
    parameter int SP_RESET = 2047
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd,
    input  logic              by_two,
    input  logic              up,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_plus1,
    output logic [ADDR_W-1:0] sp_plus2,
    output logic [ADDR_W-1:0] sp_minus1,
    output logic              push1_ok,
    output logic              push2_ok,
    output logic              pop1_ok,
    output logic              pop2_ok
);

    localparam logic [ADDR_W:0] SP_TOP = (ADDR_W+1)'(SP_RESET);

    logic [ADDR_W-1:0] sp_reg;
    logic [ADDR_W-1:0] sp_next;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W:0]   sp_ext;

    assign step    = by_two ? ADDR_W'(2) : ADDR_W'(1);
    assign sp_next = !upd ? sp_reg : (up ? sp_reg + step : sp_reg - step);

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_reg <= ADDR_W'(SP_RESET);
        end else begin
            sp_reg <= sp_next;
        end
    end

    // Pop checks use one extra bit so SP near the top of the address space cannot wrap.
    assign sp_ext    = {1'b0, sp_reg};
    assign sp        = sp_reg;
    assign sp_plus1  = sp_reg + ADDR_W'(1);
    assign sp_plus2  = sp_reg + ADDR_W'(2);
    assign sp_minus1 = sp_reg - ADDR_W'(1);
    assign push1_ok  = sp_reg >= ADDR_W'(1);
    assign push2_ok  = sp_reg >= ADDR_W'(2);
    assign pop1_ok   = (sp_ext + (ADDR_W+1)'(1)) <= SP_TOP;
    assign pop2_ok   = (sp_ext + (ADDR_W+1)'(2)) <= SP_TOP;

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage sequencer: loads, stores and 16/32-bit stack transfers, with all
// data_memory controls driven from flops and a stall while busy.
module mem_access_unit #(
    parameter int ADDR_W    = mem_pkg::ADDR_W,
    parameter int DATA_W    = mem_pkg::DATA_W,
    parameter int MEM_DEPTH = 2048,
    parameter int SP_RESET  = 2047
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [2:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                req_ready,
    output logic                stall,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_read,
    output logic                mem_write,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                rsp_valid,
    output logic [2*DATA_W-1:0] rsp_data,
    output logic                err,
    output logic [ADDR_W-1:0]   sp
);
    import mem_pkg::*;

    state_e              state_reg, state_next;
    mem_op_e             op_reg, op_next;
    mem_op_e             op_in;
    logic [2*DATA_W-1:0] wdata_reg, wdata_next;
    logic                fault_reg, fault_next;
    logic [DATA_W-1:0]   lo_reg, lo_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
    logic                mem_read_reg, mem_read_next;
    logic                mem_write_reg, mem_write_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [2*DATA_W-1:0] rsp_data_reg, rsp_data_next;
    logic                err_reg, err_next;

    logic                sp_upd, sp_by_two, sp_up;
    logic [ADDR_W-1:0]   sp_plus1, sp_plus2, sp_minus1;
    logic                push1_ok, push2_ok, pop1_ok, pop2_ok;
    logic                accept, accept_fault, addr_bad;

    stack_pointer #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clk       (clk),
        .rst       (rst),
        .upd       (sp_upd),
        .by_two    (sp_by_two),
        .up        (sp_up),
        .sp        (sp),
        .sp_plus1  (sp_plus1),
        .sp_plus2  (sp_plus2),
        .sp_minus1 (sp_minus1),
        .push1_ok  (push1_ok),
        .push2_ok  (push2_ok),
        .pop1_ok   (pop1_ok),
        .pop2_ok   (pop2_ok)
    );

    assign op_in    = mem_op_e'(req_op);
    assign addr_bad = req_addr >= ADDR_W'(MEM_DEPTH);
    assign accept   = req_valid && (op_in != OP_NOP) && (req_op <= 3'd6);

    always_comb begin
        accept_fault = 1'b0;
        case (op_in)
            OP_LOAD, OP_STORE: accept_fault = addr_bad;
            OP_PUSH16:         accept_fault = ~push1_ok;
            OP_PUSH32:         accept_fault = ~push2_ok;
            OP_POP16:          accept_fault = ~pop1_ok;
            OP_POP32:          accept_fault = ~pop2_ok;
            default:           accept_fault = 1'b0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        wdata_next     = wdata_reg;
        fault_next     = fault_reg;
        lo_next        = lo_reg;
        mem_addr_next  = '0;
        mem_wdata_next = '0;
        mem_read_next  = 1'b0;
        mem_write_next = 1'b0;
        rsp_valid_next = 1'b0;
        rsp_data_next  = '0;
        err_next       = 1'b0;
        sp_upd         = 1'b0;
        sp_by_two      = 1'b0;
        sp_up          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ACC1;
                    op_next    = op_in;
                    wdata_next = req_wdata;
                    fault_next = accept_fault;
                    // A faulted request still spends ACC1 on an idle bus so err lines up with the normal slot.
                    if (!accept_fault) begin
                        case (op_in)
                            OP_LOAD: begin
                                mem_addr_next = req_addr;
                                mem_read_next = 1'b1;
                            end
                            OP_STORE: begin
                                mem_addr_next  = req_addr;
                                mem_wdata_next = req_wdata[DATA_W-1:0];
                                mem_write_next = 1'b1;
                            end
                            OP_PUSH16: begin
                                mem_addr_next  = sp;
                                mem_wdata_next = req_wdata[DATA_W-1:0];
                                mem_write_next = 1'b1;
                            end
                            OP_PUSH32: begin
                                mem_addr_next  = sp;
                                mem_wdata_next = req_wdata[2*DATA_W-1:DATA_W];
                                mem_write_next = 1'b1;
                            end
                            OP_POP16, OP_POP32: begin
                                mem_addr_next = sp_plus1;
                                mem_read_next = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            ST_ACC1: begin
                lo_next = mem_rdata;
                if (!fault_reg && is_wide(op_reg)) begin
                    state_next = ST_ACC2;
                    if (op_reg == OP_PUSH32) begin
                        mem_addr_next  = sp_minus1;
                        mem_wdata_next = wdata_reg[DATA_W-1:0];
                        mem_write_next = 1'b1;
                    end else begin
                        mem_addr_next = sp_plus2;
                        mem_read_next = 1'b1;
                    end
                end else begin
                    state_next     = ST_IDLE;
                    rsp_valid_next = 1'b1;
                    err_next       = fault_reg;
                    if (!fault_reg) begin
                        if (op_reg == OP_LOAD || op_reg == OP_POP16) begin
                            rsp_data_next = {{DATA_W{1'b0}}, mem_rdata};
                        end
                        sp_upd = (op_reg == OP_PUSH16) || (op_reg == OP_POP16);
                        sp_up  = (op_reg == OP_POP16);
                    end
                end
            end

            ST_ACC2: begin
                state_next     = ST_IDLE;
                rsp_valid_next = 1'b1;
                sp_upd         = 1'b1;
                sp_by_two      = 1'b1;
                sp_up          = (op_reg == OP_POP32);
                if (op_reg == OP_POP32) begin
                    rsp_data_next = {mem_rdata, lo_reg};
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_NOP;
            wdata_reg     <= '0;
            fault_reg     <= 1'b0;
            lo_reg        <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            wdata_reg     <= wdata_next;
            fault_reg     <= fault_next;
            lo_reg        <= lo_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            err_reg       <= err_next;
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign stall     = req_valid & ~req_ready;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: reference stack/memory model predicts each
// response, a monitor pops expectations as the DUT responds.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        err;
    logic [31:0] sp;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem     [0:2047];
    logic [15:0] ref_mem [0:2047];
    int          mdl_sp;
    int          n_vec;
    int          n_bad;

    mem_access_unit #(
        .MEM_DEPTH (2048),
        .SP_RESET  (2047)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .stall     (stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .err       (err),
        .sp        (sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_memory stand-in: level-sensitive write sampled on the clock, combinational read
    always @(posedge clk) begin
        if (mem_write && mem_addr < 32'd2048) mem[mem_addr[10:0]] <= mem_wdata;
    end
    assign mem_rdata = (mem_addr < 32'd2048) ? mem[mem_addr[10:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_err", 32'(err), 32'(e.err));
            end
        end
    end

    // Call at a negedge with the DUT idle; returns at the negedge of the response cycle.
    task automatic issue(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wd);
        logic        e;
        logic [31:0] d;
        logic [31:0] got_data;
        logic        got_err;
        int          nwr, nrd, lat, n, stalls, wr, rd;
        bit          got;
        exp_t        x;
        e = 1'b0; d = 32'h0; nwr = 0; nrd = 0;
        case (op)
            OP_LOAD: begin
                e = addr >= 32'd2048;
                if (!e) begin d = {16'h0, ref_mem[addr[10:0]]}; nrd = 1; end
            end
            OP_STORE: begin
                e = addr >= 32'd2048;
                if (!e) begin ref_mem[addr[10:0]] = wd[15:0]; nwr = 1; end
            end
            OP_PUSH16: begin
                e = mdl_sp < 1;
                if (!e) begin ref_mem[mdl_sp] = wd[15:0]; mdl_sp = mdl_sp - 1; nwr = 1; end
            end
            OP_POP16: begin
                e = mdl_sp + 1 > 2047;
                if (!e) begin d = {16'h0, ref_mem[mdl_sp+1]}; mdl_sp = mdl_sp + 1; nrd = 1; end
            end
            OP_PUSH32: begin
                e = mdl_sp < 2;
                if (!e) begin
                    ref_mem[mdl_sp] = wd[31:16]; ref_mem[mdl_sp-1] = wd[15:0];
                    mdl_sp = mdl_sp - 2; nwr = 2;
                end
            end
            OP_POP32: begin
                e = mdl_sp + 2 > 2047;
                if (!e) begin
                    d = {ref_mem[mdl_sp+2], ref_mem[mdl_sp+1]};
                    mdl_sp = mdl_sp + 2; nrd = 2;
                end
            end
            default: ;
        endcase
        lat = (!e && (op == OP_PUSH32 || op == OP_POP32)) ? 3 : 2;
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);

        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        n = 0; stalls = 0; wr = 0; rd = 0; got = 0;
        got_data = 32'h0; got_err = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            wr += int'(mem_write);
            rd += int'(mem_read);
            if (rsp_valid) begin
                got = 1; got_data = rsp_data; got_err = err;
                req_valid = 1'b0;
            end else begin
                stalls += int'(stall);
                // Garbage on the request bus while busy must be ignored.
                req_valid = 1'b1; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
            end
        end
        req_valid = 1'b0;
        if (!got) check("rsp_timeout", 32'd0, 32'd1);
        check("latency", 32'(n), 32'(lat));
        check("stall_cycles", 32'(stalls), 32'(lat - 1));
        check("write_cycles", 32'(wr), 32'(nwr));
        check("read_cycles", 32'(rd), 32'(nrd));
        check("sp", sp, 32'(mdl_sp));
        $display("txn %-9s addr=%h wdata=%h -> rsp=%h err=%b sp=%0d", op.name(), addr, wd,
                 got_data, got_err, sp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0; n_bad = 0; mdl_sp = 2047;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_sp", sp, 32'd2047);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // NOP is accepted silently
        req_valid = 1'b1; req_op = OP_NOP;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("nop_ready", 32'(req_ready), 32'd1);
        check("nop_bus", {30'd0, mem_read, mem_write}, 32'd0);
        @(negedge clk);

        issue(OP_STORE, 32'h10, 32'h0000_1234);
        issue(OP_LOAD,  32'h10, 32'h0);
        check("m_0x10", {16'h0, mem[16]}, 32'h1234);

        issue(OP_PUSH32, 32'h0, 32'hDEAD_BEEF);
        check("m_2047", {16'h0, mem[2047]}, 32'hDEAD);
        check("m_2046", {16'h0, mem[2046]}, 32'hBEEF);
        issue(OP_POP32, 32'h0, 32'h0);

        issue(OP_POP16, 32'h0, 32'h0);
        issue(OP_LOAD, 32'd2048, 32'h0);
        issue(OP_STORE, 32'hFFFF_0000, 32'h5555);
        issue(OP_LOAD, 32'd2047, 32'h0);

        issue(OP_PUSH16, 32'h0, 32'h0000_AAAA);
        issue(OP_POP16, 32'h0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: issue(OP_STORE, 32'($urandom_range(0, 2100)), $urandom);
                1: issue(OP_LOAD, 32'($urandom_range(0, 2100)), 32'h0);
                2: issue(OP_PUSH16, 32'h0, $urandom);
                default: issue(OP_POP16, 32'h0, 32'h0);
            endcase
        end
        while (mdl_sp < 2047) issue(OP_POP16, 32'h0, 32'h0);

        // Reset during the second word of a PUSH32
        req_valid = 1'b1; req_op = OP_PUSH32; req_addr = 32'h0; req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("acc2_write", 32'(mem_write), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_write", 32'(mem_write), 32'd0);
        check("abort_sp", sp, 32'd2047);
        check("abort_rsp", 32'(rsp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        ref_mem[2047] = 16'hCAFE;
        ref_mem[2046] = 16'hF00D;
        mdl_sp = 2047;
        @(negedge clk);
        check("abort_m2047", {16'h0, mem[2047]}, 32'hCAFE);
        issue(OP_POP16, 32'h0, 32'h0);

        // Fill the stack to its floor and probe the overflow limits
        while (mdl_sp >= 2) issue(OP_PUSH32, 32'h0, $urandom);
        issue(OP_PUSH32, 32'h0, 32'h1111_2222);
        issue(OP_PUSH16, 32'h0, 32'h0000_3333);
        issue(OP_PUSH16, 32'h0, 32'h0000_4444);
        issue(OP_POP16, 32'h0, 32'h0);
        issue(OP_POP32, 32'h0, 32'h0);
        issue(OP_POP32, 32'h0, 32'h0);

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage sequencer that sits between the EX/MEM pipeline register and data_memory. It accepts one memory request per instruction, performs loads, stores, and stack pushes/pops, and splits 32-bit stack transfers (PC save/restore for CALL/RET/INT/RTI) into two 16-bit word accesses. It owns the stack pointer and raises a stall while a multi-cycle access is in flight. All data_memory control lines are driven from flops, because data_memory writes are level-sensitive.

## Interface
- ADDR_W, 32, address width on both sides
- DATA_W, 16, data_memory word width
- MEM_DEPTH, 2048, words in data_memory; valid addresses are 0..MEM_DEPTH-1
- SP_RESET, 2047, stack pointer value after reset (top of memory)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present from EX/MEM
- req_op  in  3  operation code: NOP, LOAD, STORE, PUSH16, POP16, PUSH32, POP32
- req_addr  in  32  effective address for LOAD/STORE; ignored for stack ops
- req_wdata  in  32  store/push data; [15:0] for 16-bit ops
- req_ready  out  1  high only in IDLE
- stall  out  1  req_valid & ~req_ready, sent to the hazard unit
- mem_addr  out  32  registered; to data_memory Address
- mem_wdata  out  16  registered; to data_memory DataIn
- mem_read  out  1  registered; to data_memory MemoryRead
- mem_write  out  1  registered; to data_memory MemoryWrite
- mem_rdata  in  16  from data_memory DataOut (combinational read)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  load/pop result, zero-extended for 16-bit ops; 0 for STORE/PUSH
- err  out  1  valid with rsp_valid; access was suppressed
- sp  out  32  current stack pointer

## Operation
- **Stack convention:** SP points to the next free word and the stack grows down.
  - PUSH16: write M[SP], then SP−1.
  - POP16: read M[SP+1], then SP+1.
  - PUSH32: write M[SP]=wdata[31:16] and M[SP−1]=wdata[15:0], then SP−2.
  - POP32: read the low word from M[SP+1] and the high word from M[SP+2], then SP+2.
- **States:** IDLE, ACC1, ACC2.
  - IDLE: accept when req_valid and req_op≠NOP. Latch op, address, and data. Compute the first access into the mem_* flops. Go to ACC1. An accepted NOP produces no response.
  - ACC1: the first word is on the memory bus. For 16-bit ops, LOAD, and STORE, go to IDLE. For PUSH32/POP32, load the second access and go to ACC2.
  - ACC2: the second word is on the bus. Go to IDLE.
- **Read capture:** mem_rdata is captured at the end of each read cycle.
- **SP update:** SP is updated at the end of the last access cycle only.
- **Response:** rsp_valid, rsp_data, and err are registered. They pulse in the first IDLE cycle after the last access.
- **Bus idle values:** outside ACC1/ACC2, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- **Fault checks** (evaluated at accept; on a fault go straight to ACC1 with mem_read and mem_write held at 0, SP unchanged, err=1):
  - LOAD/STORE: req_addr ≥ MEM_DEPTH.
  - PUSH16: SP < 1.
  - PUSH32: SP < 2.
  - POP16: SP+1 > SP_RESET.
  - POP32: SP+2 > SP_RESET.

## Timing
- **Reset values:** state=IDLE, sp=SP_RESET. All other outputs 0, except req_ready=1.
- **Latency:** accept at edge E.
  - 16-bit ops: access in cycle E+1; rsp_valid in cycle E+2.
  - 32-bit ops: accesses in cycles E+1 and E+2; rsp_valid in cycle E+3.
- **Back-to-back:** a new request may be accepted in the cycle where rsp_valid=1. Sustained throughput is one 16-bit op every 2 cycles.
- **Memory write pulse:** mem_write is high for exactly one cycle per word. mem_addr and mem_wdata are stable for that whole cycle.
- **Reset mid-operation:** reset during ACC1/ACC2 aborts the op. Next cycle is IDLE with mem_write=0 and sp=SP_RESET. A half-written PUSH32 leaves the high word in memory, which is acceptable. No rsp_valid is produced.
- **Request changes:** req_* changes while not in IDLE are ignored.

## Structure
- **mem_pkg:** op encoding enum, FSM state enum, ADDR_W/DATA_W constants.
- **Sub-module stack_pointer:** SP register with reset to SP_RESET, inc/dec by 1 or 2, and push/pop bound-check outputs.

## Test plan
- **Store then load:** STORE addr=0x10 wdata=0x1234, then LOAD 0x10. Expect mem_write high one cycle; load rsp_data=0x00001234 at E+2.
- **PUSH32/POP32 round trip:** PUSH32 0xDEADBEEF from reset. Expect M[2047]=0xDEAD, M[2046]=0xBEEF, sp=2045. Then POP32: rsp_data=0xDEADBEEF at E+3, sp=2047; stall high for two cycles.
- **Underflow:** POP16 at sp=2047. Expect err=1 with rsp_valid, mem_read never asserted, sp stays 2047.
- **Overflow and range:** PUSH32 at sp=1 gives err with no write. LOAD addr=2048 gives err.
- **Reset mid-push:** assert rst during ACC2 of a PUSH32. Expect next cycle IDLE, mem_write=0, sp=2047, rsp_valid=0.
- **Back-to-back:** PUSH16 0xAAAA then POP16 accepted in the rsp_valid cycle. Expect POP rsp_data=0x0000AAAA and sp returning to 2047.
